unit_l_arbiter: RTL
===================

# unit_l_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit logic unit (`unit_L`: AND/OR/XOR selected by `f1,f0`). It accepts operation requests from two independent clients, grants one at a time, and drives the latched operands and select lines into an internal `unit_L` instance. It registers the result and holds it on a valid/ready output channel until the consumer takes it. It sits between the instruction-side clients and the writeback path.

## Interface
Parameters:
- `W`, 32: operand/result width (the `unit_L` instance is fixed at 32; only 32 is supported).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0` / `req1` input 1: request from client 0 / 1.
- `op0` / `op1` input 2: select `{f1,f0}`; 01=AND, 10=OR, 11=XOR, 00=invalid.
- `a0`, `b0` / `a1`, `b1` input 32: operands.
- `ack0` / `ack1` output 1: one-cycle pulse meaning the request was accepted and operands latched.
- `res` output 32: registered result.
- `res_id` output 1: client that owns `res`.
- `res_err` output 1: the op was 00, so `res` = 0.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer accepts the result.

## Operation
- State machine: IDLE, EXEC, HOLD. Reset state is IDLE.
- IDLE:
  - If neither `req` is high, stay in IDLE.
  - Otherwise choose the winner. With one request, that request wins. With both, the client named by pointer `rr` wins.
  - On the clock edge: latch `op`, `a`, `b` and the winner id; register `ack_winner`=1; set `rr` = ~winner; go to EXEC.
- EXEC:
  - Latched `op[1]`→`f1` and `op[0]`→`f0` drive `unit_L` together with the latched `a`, `b`.
  - On the edge: `res` ← unit output, `res_id` ← winner, `res_err` ← (op==00), `res_valid` ← 1. Go to HOLD.
  - `ack` returns to 0.
- HOLD:
  - `res`, `res_id`, `res_err` and `res_valid` stay stable.
  - When `res_valid && res_ready` is sampled high: `res_valid` ← 0, go to IDLE.
  - Requests are not sampled in HOLD.
- Client rules:
  - Hold `req`, `op`, `a`, `b` stable until `ack` is seen.
  - Drop `req` in the cycle after `ack` unless issuing a new request.
  - A `req` still high when the arbiter returns to IDLE is treated as a new request.
- Op 00 still runs through EXEC/HOLD and yields `res`=0 with `res_err`=1. It is not dropped.
- Reset values: `ack0`=`ack1`=0, `res`=0, `res_id`=0, `res_err`=0, `res_valid`=0, `rr`=0, latched operands 0.

## Timing
- Request sampled in IDLE at edge N:
  - `ack` is high during cycle N→N+1 (EXEC).
  - `res_valid` rises at edge N+1.
- Minimum occupancy is 3 cycles per operation (IDLE, EXEC, HOLD with `res_ready` already high). Peak throughput is 1 op per 3 cycles.
- `res_ready` held low keeps the arbiter in HOLD indefinitely. There is no timeout, and further requests wait.
- Fairness: with both clients requesting continuously, grants alternate 0,1,0,1… starting from client 0 after reset. `rr` updates only on a grant.
- `ack0` and `ack1` are never high in the same cycle. `ack` never coincides with an IDLE→EXEC decision for the other client.
- Asynchronous reset in any state:
  - Immediately returns to IDLE and clears all outputs.
  - An in-flight result is discarded without a handshake.
  - A request latched but not yet delivered is lost; the client re-requests.
- A `res_ready` pulse while `res_valid`=0 is ignored.

## Test plan
- Single client, AND:
  - Stimulus: client 0 sends `op0`=01, `a0`=0xDC754CD2, `b0`=0x4124F055; `res_ready`=1.
  - Response: `ack0` one cycle after sampling; `res`=0x40244050, `res_id`=0, `res_err`=0; `res_valid` for exactly one cycle.
- OR, then XOR, same operands:
  - Stimulus: client 1 sends `op1`=10, then `op1`=11.
  - Response: `res`=0xDD75FCD7 with `res_id`=1, then `res`=0x9D51BC87 with `res_id`=1.
- Contention:
  - Stimulus: `req0`=`req1`=1 continuously after reset, with 4 ops.
  - Response: grant order 0,1,0,1; `ack0` and `ack1` never overlap.
- Backpressure:
  - Stimulus: `res_ready`=0 for 5 cycles after `res_valid` rises.
  - Response: `res`, `res_id` and `res_valid` stay stable; no `ack` during the stall; handshake completes on the cycle `res_ready`=1; the next request is accepted afterwards.
- Invalid op:
  - Stimulus: `op0`=00, `a0`=`b0`=0xFFFFFFFF.
  - Response: `res`=0, `res_err`=1, `res_valid` asserted normally.
- Reset mid-operation:
  - Stimulus: assert `rst` in EXEC, then separately in HOLD.
  - Response: outputs go to 0 without waiting for a clock edge; after release, state is IDLE and `rr`=0.

Source files
------------

// File: rtl/unit_l_arbiter.sv
// unit_l_arbiter: two-client round-robin arbiter/sequencer for the shared
// 32-bit logic unit (AND/OR/XOR on {f1,f0}). One op in flight at a time:
// IDLE grants, EXEC computes, HOLD presents the result on a valid/ready channel.
module unit_l_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] res,
  output logic         res_id,
  output logic         res_err,
  output logic         res_valid,
  input  logic         res_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Operands and owner captured at grant; held stable through EXEC.
  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         id;
  } req_t;

  logic [1:0]   state;
  logic         rr;
  req_t         lat;
  logic         win;
  logic         grant;
  logic [W-1:0] l_out;

  // Winner: a lone requester wins outright; on contention the rr pointer decides.
  always_comb begin
    win   = (req0 && req1) ? rr : req1;
    grant = (state == IDLE) && (req0 || req1);
  end

  // Shared logic unit, driven only from latched operands. Select 00 yields 0.
  generate
    begin : u_unit_l
      logic f1, f0;
      assign f1 = lat.op[1];
      assign f0 = lat.op[0];
      // AND/OR/XOR selected by {f1,f0}
      always_comb begin
        l_out = '0;
        case ({f1, f0})
          2'b01:   l_out = lat.a & lat.b;
          2'b10:   l_out = lat.a | lat.b;
          2'b11:   l_out = lat.a ^ lat.b;
          default: l_out = '0;
        endcase
      end
    end
  endgenerate

  // Sequencer: grant in IDLE, register result in EXEC, hold until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      lat       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res       <= '0;
      res_id    <= 1'b0;
      res_err   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            lat.op <= win ? op1 : op0;
            lat.a  <= win ? a1  : a0;
            lat.b  <= win ? b1  : b0;
            lat.id <= win;
            ack0   <= ~win;
            ack1   <= win;
            rr     <= ~win;
            state  <= EXEC;
          end
        end
        EXEC: begin
          res       <= l_out;
          res_id    <= lat.id;
          res_err   <= (lat.op == 2'b00);
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
